// File: rtl/ps2_key_decoder_if.sv
// Key-event bus from a PS/2 keyboard decoder to its consumers (game select, game cores).
interface ps2_key_decoder_if;
  logic [7:0] o_key;
  logic       o_key_valid;
  logic       o_extended;
  logic       o_break;
  logic [7:0] o_break_code;
  logic       o_err;

  modport master (
    output o_key, o_key_valid, o_extended, o_break, o_break_code, o_err
  );

  modport slave (
    input o_key, o_key_valid, o_extended, o_break, o_break_code, o_err
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 receiver: frames bytes, folds E0/F0 prefixes, emits one-cycle key/break events.
// Optional typematic repeat suppression when PS2_REPEAT_FILTER_EN is defined.
module ps2_key_decoder #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_ps2_clk,
  input  logic               i_ps2_dat,
  ps2_key_decoder_if.master  key_if
);

  localparam int unsigned SYNC_W = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int unsigned TMO_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t            r_state, w_state_next;
  logic [SYNC_W-1:0] r_clk_sync, r_dat_sync;
  logic              r_clk_prev;
  logic              w_clk_s, w_dat_s, w_fall, w_timeout, w_byte_ok;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic [7:0]        r_shift, w_shift_next;
  logic [2:0]        r_bit_cnt, w_bit_cnt_next;
  logic              r_parity, w_parity_next;
  logic              r_ext, w_ext_next, r_brk, w_brk_next;
  logic [7:0]        r_key, w_key_next, r_break_code, w_break_code_next;
  logic              r_key_valid, w_key_valid_next, r_extended, w_extended_next;
  logic              r_break, w_break_next, r_err, w_err_next;
`ifdef PS2_REPEAT_FILTER_EN
  logic [7:0]        r_held_code, w_held_code_next;
  logic              r_held_ext, w_held_ext_next, r_held, w_held_next;
  logic              w_held_match;
`endif

  // Synchronizers preset to the idle-high bus level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_W-2:0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_W-2:0], i_ps2_dat};
      r_clk_prev <= r_clk_sync[SYNC_W-1];
    end
  end

  assign w_clk_s   = r_clk_sync[SYNC_W-1];
  assign w_dat_s   = r_dat_sync[SYNC_W-1];
  assign w_fall    = r_clk_prev & ~w_clk_s;
  assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_tmo_cnt == TMO_LAST);

  // Saturating inactivity counter, only meaningful inside a frame
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tmo_cnt <= '0;
    end else if (w_fall || r_state == S_IDLE) begin
      r_tmo_cnt <= '0;
    end else if (r_tmo_cnt != TMO_LAST) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_parity     <= 1'b0;
      r_ext        <= 1'b0;
      r_brk        <= 1'b0;
      r_key        <= '0;
      r_key_valid  <= 1'b0;
      r_extended   <= 1'b0;
      r_break      <= 1'b0;
      r_break_code <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_shift      <= w_shift_next;
      r_bit_cnt    <= w_bit_cnt_next;
      r_parity     <= w_parity_next;
      r_ext        <= w_ext_next;
      r_brk        <= w_brk_next;
      r_key        <= w_key_next;
      r_key_valid  <= w_key_valid_next;
      r_extended   <= w_extended_next;
      r_break      <= w_break_next;
      r_break_code <= w_break_code_next;
      r_err        <= w_err_next;
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_held_code <= '0;
      r_held_ext  <= 1'b0;
      r_held      <= 1'b0;
    end else begin
      r_held_code <= w_held_code_next;
      r_held_ext  <= w_held_ext_next;
      r_held      <= w_held_next;
    end
  end

  assign w_held_match = r_held && (r_held_code == r_shift) && (r_held_ext == r_ext);
`endif

  // Frame FSM, byte acceptance and prefix decode
  always_comb begin
    w_state_next      = r_state;
    w_shift_next      = r_shift;
    w_bit_cnt_next    = r_bit_cnt;
    w_parity_next     = r_parity;
    w_ext_next        = r_ext;
    w_brk_next        = r_brk;
    w_key_next        = '0;
    w_key_valid_next  = 1'b0;
    w_extended_next   = 1'b0;
    w_break_next      = 1'b0;
    w_break_code_next = '0;
    w_err_next        = 1'b0;
    w_byte_ok         = 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
    w_held_code_next  = r_held_code;
    w_held_ext_next   = r_held_ext;
    w_held_next       = r_held;
`endif

    if (w_timeout) begin
      w_state_next = S_IDLE;
      w_err_next   = 1'b1;
      w_ext_next   = 1'b0;
      w_brk_next   = 1'b0;
    end else if (w_fall) begin
      case (r_state)
        S_IDLE: begin
          if (!w_dat_s) begin
            w_state_next   = S_DATA;
            w_bit_cnt_next = '0;
          end
        end
        S_DATA: begin
          w_shift_next = {w_dat_s, r_shift[7:1]};
          if (r_bit_cnt == 3'd7) begin
            w_state_next = S_PARITY;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 3'd1;
          end
        end
        S_PARITY: begin
          w_parity_next = w_dat_s;
          w_state_next  = S_STOP;
        end
        S_STOP: begin
          w_state_next = S_IDLE;
          if (w_dat_s && (^{r_shift, r_parity})) begin
            w_byte_ok = 1'b1;
          end else begin
            w_err_next = 1'b1;
            w_ext_next = 1'b0;
            w_brk_next = 1'b0;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end

    if (w_byte_ok) begin
      if (r_shift == CODE_EXT) begin
        w_ext_next = 1'b1;
      end else if (r_shift == CODE_BRK) begin
        w_brk_next = 1'b1;
      end else begin
        w_ext_next = 1'b0;
        w_brk_next = 1'b0;
        if (r_brk) begin
          w_break_next      = 1'b1;
          w_break_code_next = r_shift;
          w_extended_next   = r_ext;
`ifdef PS2_REPEAT_FILTER_EN
          if (w_held_match) w_held_next = 1'b0;
`endif
        end else if (r_shift != 8'h00) begin
`ifdef PS2_REPEAT_FILTER_EN
          if (!w_held_match) begin
            w_key_next       = r_shift;
            w_key_valid_next = 1'b1;
            w_extended_next  = r_ext;
            w_held_code_next = r_shift;
            w_held_ext_next  = r_ext;
            w_held_next      = 1'b1;
          end
`else
          w_key_next       = r_shift;
          w_key_valid_next = 1'b1;
          w_extended_next  = r_ext;
`endif
        end
      end
    end
  end

  assign key_if.o_key        = r_key;
  assign key_if.o_key_valid  = r_key_valid;
  assign key_if.o_extended   = r_extended;
  assign key_if.o_break      = r_break;
  assign key_if.o_break_code = r_break_code;
  assign key_if.o_err        = r_err;

endmodule
